argmax_stream: RTL

ARGMAX_STREAM -- requirements
Module: argmax_stream

---
 rtl/argmax_stream.sv | 121 ++++++++++++
 1 files changed

// File: rtl/argmax_stream.sv
// Streaming argmax: consumes NUM_INPUTS signed scores per frame, emits the index of the largest.
// Optional macro ARGMAX_SCORE_OUT_EN adds the m_score output carrying the winning score.
module argmax_stream #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_INPUTS  = 10,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [BIT_WIDTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [INDEX_WIDTH-1:0]      m_index
`ifdef ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [BIT_WIDTH-1:0] m_score
`endif
);

  // state | meaning
  // IDLE  | waiting for score 0 of a frame
  // ACCUM | scores 1..NUM_INPUTS-1 being compared against the running best
  // DONE  | result presented, upstream stalled until the result handshake
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_CNT = INDEX_WIDTH'(NUM_INPUTS - 1);

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $error("argmax_stream: NUM_INPUTS must be at least 2");
  end

  state_t                        r_state;
  logic [INDEX_WIDTH-1:0]        r_cnt;
  logic [INDEX_WIDTH-1:0]        r_best_idx;
  logic signed [BIT_WIDTH-1:0]   r_best_val;
  logic [INDEX_WIDTH-1:0]        r_m_index;
  logic                          r_s_ready;
  logic                          r_m_valid;

  logic                          w_accept;
  logic                          w_better;
  logic [INDEX_WIDTH-1:0]        w_next_idx;
  logic signed [BIT_WIDTH-1:0]   w_next_val;

  assign w_accept   = s_valid && r_s_ready;
  // strict compare keeps the earliest index on ties
  assign w_better   = s_data > r_best_val;
  assign w_next_idx = w_better ? r_cnt : r_best_idx;
  assign w_next_val = w_better ? s_data : r_best_val;

`ifdef ARGMAX_SCORE_OUT_EN
  logic signed [BIT_WIDTH-1:0]   r_m_score;
  assign m_score = r_m_score;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_m_index  <= '0;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
      r_m_score  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
          if (w_accept) begin
            r_best_val <= s_data;
            r_best_idx <= '0;
            r_cnt      <= INDEX_WIDTH'(1);
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_best_val <= w_next_val;
            r_best_idx <= w_next_idx;
            if (r_cnt == LAST_CNT) begin
              // result registered on the same edge as the last accept
              r_state   <= DONE;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
              r_m_index <= w_next_idx;
`ifdef ARGMAX_SCORE_OUT_EN
              r_m_score <= w_next_val;
`endif
            end else begin
              r_cnt <= r_cnt + INDEX_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (m_ready) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_cnt     <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_index = r_m_index;

endmodule
